dm_arbiter: RTL and testbench
=============================

// Module: dm_arbiter
// PURPOSE
//  Two-port arbiter/sequencer in front of the single-port 128-word data memory (dm).
//  Port 0 = CPU load/store path, port 1 = loader/debug path. Grants one request at a
//  time, drives MemWrite/MemRead/Address/WriteData for exactly one cycle, registers
//  ReadData and returns it with a valid pulse. Out-of-range word addresses are blocked.
// PARAMETERS
//  DEPTH  128  memory depth in words; legal word addresses 0..DEPTH-1
//  AW     32   address width of ports and memory Address
//  DW     32   data width
// PORTS
//  clk        in   1   clock, rising edge
//  rst_n      in   1   asynchronous active-low reset
//  p0_req     in   1   port 0 request; held with p0_we/addr/wdata until p0_gnt
//  p0_we      in   1   1=write, 0=read
//  p0_addr    in   AW  word address
//  p0_wdata   in   DW  write data
//  p0_gnt     out  1   1-cycle grant pulse; command captured this cycle
//  p0_done    out  1   1-cycle completion pulse (reads and writes)
//  p0_rvalid  out  1   1-cycle pulse with p0_done for reads; p0_rdata valid
//  p0_rdata   out  DW  read data, held until next p0 read completes
//  p0_err     out  1   with p0_done: address >= DEPTH, no memory access made
//  p1_*       --   --  identical set for port 1
//  MemWrite   out  1   to dm write enable
//  MemRead    out  1   to dm read enable
//  Address    out  AW  to dm address
//  WriteData  out  DW  to dm write data
//  ReadData   in   DW  from dm (combinational read)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; all gnt/done/rvalid/err=0; p0_rdata=p1_rdata=0;
//   MemWrite=MemRead=0; Address=WriteData=0; RR pointer=port 1 (port 0 wins first).
//  FSM: IDLE -> ACCESS when any req in IDLE; ACCESS -> IDLE unconditionally.
//  IDLE, cycle T: winner's pX_gnt=1 (combinational); we/addr/wdata/port id/err flag
//   registered at edge ending T. Loser not granted; its req remains pending.
//  ACCESS, T+1: if err flag=0 drive MemWrite=we, MemRead=~we, Address, WriteData
//   from command regs; else all strobes 0. Outside ACCESS strobes=0, Address/WriteData=0.
//  T+2: pX_done=1; reads: ReadData captured at edge ending T+1 -> pX_rdata, pX_rvalid=1.
//   err reads: pX_rdata=0, rvalid=1, err=1. err writes: done=1, err=1, memory untouched.
//  Latency gnt->done = 2 cycles. Next grant may occur in T+2 (same cycle as done):
//   max throughput 1 access / 2 cycles.
//  No grant while in ACCESS; requests raised then wait until IDLE.
//  Requests are level; requester drops req after gnt or it is re-granted.
//  err check: addr >= DEPTH (full AW compare, no truncation/wrap).
//  Reset mid-operation: in-flight access discarded, no done/rvalid emitted; requester
//   re-issues after reset. Memory contents unaffected by arbiter reset.
// CONFIGURATION
//  DM_ARB_RR_EN defined: round-robin; on simultaneous req the port not granted last
//   wins; pointer updates on every grant. Single requester always wins immediately.
//  DM_ARB_RR_EN undefined: fixed priority, port 0 always wins; port 1 may starve;
//   no pointer register.
// TESTING
//  1 p0 write addr=5 data=0xCAFE, then p0 read addr=5 -> gnt T, MemWrite=1 Address=5 at
//    T+1, done T+2; read returns p0_rdata=0xCAFE with rvalid at gnt+2.
//  2 p0,p1 both read same cycle, fixed prio -> p0 gnt T, p1 gnt T+2; RR build: same
//    first, then with both held continuously grants alternate p0,p1,p0,p1.
//  3 p1 read addr=128 (DEPTH=128) -> MemRead stays 0, p1_done=p1_rvalid=p1_err=1,
//    p1_rdata=0 at gnt+2; addr=127 -> err=0, normal access.
//  4 Back-to-back p0 reads addr 0..3 req held high -> gnts every 2 cycles, rvalid
//    coincides with next gnt, rdata sequence matches preloaded words.
//  5 rst_n low during ACCESS of p1 write -> all outputs 0 immediately, no done later;
//    after release first simultaneous request grants p0.
//  6 p0 req raised during ACCESS of p1 -> no p0_gnt until IDLE, then gnt next cycle.

Source files
------------

// File: rtl/dm_arbiter.sv
// Two-port arbiter/sequencer in front of the single-port data memory: one access per grant,
// 2-cycle gnt->done latency. Define DM_ARB_RR_EN for round-robin, otherwise port 0 has fixed priority.
module dm_arbiter #(
    parameter int DEPTH = 128,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          p0_req_i,
    input  logic          p0_we_i,
    input  logic [AW-1:0] p0_addr_i,
    input  logic [DW-1:0] p0_wdata_i,
    output logic          p0_gnt_o,
    output logic          p0_done_o,
    output logic          p0_rvalid_o,
    output logic [DW-1:0] p0_rdata_o,
    output logic          p0_err_o,
    input  logic          p1_req_i,
    input  logic          p1_we_i,
    input  logic [AW-1:0] p1_addr_i,
    input  logic [DW-1:0] p1_wdata_i,
    output logic          p1_gnt_o,
    output logic          p1_done_o,
    output logic          p1_rvalid_o,
    output logic [DW-1:0] p1_rdata_o,
    output logic          p1_err_o,
    output logic          MemWrite_o,
    output logic          MemRead_o,
    output logic [AW-1:0] Address_o,
    output logic [DW-1:0] WriteData_o,
    input  logic [DW-1:0] ReadData_i
);
    localparam logic ST_IDLE   = 1'b0;
    localparam logic ST_ACCESS = 1'b1;
    localparam logic [AW-1:0] DEPTH_W = AW'(DEPTH);

    logic          state_q, state_d;
    logic          cmd_we_q, cmd_we_d;
    logic          cmd_port_q, cmd_port_d;
    logic          cmd_err_q, cmd_err_d;
    logic [AW-1:0] cmd_addr_q, cmd_addr_d;
    logic [DW-1:0] cmd_wdata_q, cmd_wdata_d;
    logic          done0_q, done1_q, rvalid0_q, rvalid1_q, err0_q, err1_q;
    logic [DW-1:0] rdata0_q, rdata1_q;
    logic          win0, win1, gnt0, gnt1, any_gnt, in_access, mem_en;

`ifdef DM_ARB_RR_EN
    // last_q = 1 when port 1 received the most recent grant
    logic last_q;
    always_comb begin
        win0 = p0_req_i & (~p1_req_i | last_q);
        win1 = p1_req_i & (~p0_req_i | ~last_q);
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)      last_q <= 1'b1;
        else if (any_gnt) last_q <= gnt1;
    end
`else
    always_comb begin
        win0 = p0_req_i;
        win1 = p1_req_i & ~p0_req_i;
    end
`endif

    // Grants are gated by rst_ni so every output reads 0 while reset is held.
    always_comb begin
        gnt0    = win0 & (state_q == ST_IDLE) & rst_ni;
        gnt1    = win1 & (state_q == ST_IDLE) & rst_ni;
        any_gnt = gnt0 | gnt1;
        state_d = (state_q == ST_IDLE) ? (any_gnt ? ST_ACCESS : ST_IDLE) : ST_IDLE;
        cmd_port_d  = gnt1;
        cmd_we_d    = gnt1 ? p1_we_i    : p0_we_i;
        cmd_addr_d  = gnt1 ? p1_addr_i  : p0_addr_i;
        cmd_wdata_d = gnt1 ? p1_wdata_i : p0_wdata_i;
        cmd_err_d   = cmd_addr_d >= DEPTH_W;
    end

    always_comb begin
        in_access   = (state_q == ST_ACCESS);
        mem_en      = in_access & ~cmd_err_q;
        MemWrite_o  = mem_en & cmd_we_q;
        MemRead_o   = mem_en & ~cmd_we_q;
        Address_o   = mem_en ? cmd_addr_q  : '0;
        WriteData_o = mem_en ? cmd_wdata_q : '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            cmd_we_q    <= 1'b0;
            cmd_port_q  <= 1'b0;
            cmd_err_q   <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (any_gnt) begin
                cmd_we_q    <= cmd_we_d;
                cmd_port_q  <= cmd_port_d;
                cmd_err_q   <= cmd_err_d;
                cmd_addr_q  <= cmd_addr_d;
                cmd_wdata_q <= cmd_wdata_d;
            end
        end
    end

    // Completion is reported the cycle after ACCESS; blocked reads return zero data.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            done0_q   <= in_access & ~cmd_port_q;
            done1_q   <= in_access &  cmd_port_q;
            rvalid0_q <= in_access & ~cmd_port_q & ~cmd_we_q;
            rvalid1_q <= in_access &  cmd_port_q & ~cmd_we_q;
            err0_q    <= in_access & ~cmd_port_q & cmd_err_q;
            err1_q    <= in_access &  cmd_port_q & cmd_err_q;
            if (in_access & ~cmd_we_q & ~cmd_port_q) rdata0_q <= cmd_err_q ? '0 : ReadData_i;
            if (in_access & ~cmd_we_q &  cmd_port_q) rdata1_q <= cmd_err_q ? '0 : ReadData_i;
        end
    end

    assign p0_gnt_o    = gnt0;
    assign p1_gnt_o    = gnt1;
    assign p0_done_o   = done0_q;
    assign p1_done_o   = done1_q;
    assign p0_rvalid_o = rvalid0_q;
    assign p1_rvalid_o = rvalid1_q;
    assign p0_err_o    = err0_q;
    assign p1_err_o    = err1_q;
    assign p0_rdata_o  = rdata0_q;
    assign p1_rdata_o  = rdata1_q;
endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: attached memory, a transaction-level reference scheduled by cycle
// number, per-cycle comparison, and literal checks on grant order and returned data.
module tb_dm_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req [2];
    logic        we [2];
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic [1:0]  gnt, done, rvalid, err;
    logic [31:0] rdata [2];
    logic        MemWrite, MemRead;
    logic [31:0] Address, WriteData, ReadData;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    logic [31:0] mem [128];
    logic        mem_init_done = 1'b0;
    logic [31:0] ref_mem [128];

    int          log_port [$];
    int          log_cyc [$];
    logic [31:0] rd0_seq [$];

    always #5 clk = ~clk;

    dm_arbiter dut (
        .clk_i(clk), .rst_ni(rst_n),
        .p0_req_i(req[0]), .p0_we_i(we[0]), .p0_addr_i(addr[0]), .p0_wdata_i(wdata[0]),
        .p0_gnt_o(gnt[0]), .p0_done_o(done[0]), .p0_rvalid_o(rvalid[0]),
        .p0_rdata_o(rdata[0]), .p0_err_o(err[0]),
        .p1_req_i(req[1]), .p1_we_i(we[1]), .p1_addr_i(addr[1]), .p1_wdata_i(wdata[1]),
        .p1_gnt_o(gnt[1]), .p1_done_o(done[1]), .p1_rvalid_o(rvalid[1]),
        .p1_rdata_o(rdata[1]), .p1_err_o(err[1]),
        .MemWrite_o(MemWrite), .MemRead_o(MemRead), .Address_o(Address),
        .WriteData_o(WriteData), .ReadData_i(ReadData)
    );

    // Data memory: preloaded with 0x1000+index, combinational read.
    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 128; i++) mem[i] <= 32'h1000 + i;
            mem_init_done <= 1'b1;
        end else if (MemWrite) begin
            mem[Address[6:0]] <= WriteData;
        end
    end
    assign ReadData = mem[Address[6:0]];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: each granted transaction occupies the memory in the cycle after grant and
    // completes the cycle after that; a new grant is possible once nothing is outstanding.
    initial begin : model
        bit          m_active, m_last, m_port, m_we, m_err;
        int          m_g, w;
        logic [31:0] m_addr, m_wd, m_val;
        logic [31:0] m_rd [2];
        logic [1:0]  e_gnt, e_done, e_rv, e_err;
        logic        e_mw, e_mr;
        logic [31:0] e_a, e_wd;
        for (int i = 0; i < 128; i++) ref_mem[i] = 32'h1000 + i;
        m_active = 0; m_last = 1; m_rd[0] = 0; m_rd[1] = 0;
        m_g = 0; m_port = 0; m_we = 0; m_err = 0; m_addr = 0; m_wd = 0; m_val = 0;
        forever begin
            @(negedge clk);
            cyc++;
            e_gnt = 0; e_done = 0; e_rv = 0; e_err = 0;
            e_mw = 0; e_mr = 0; e_a = 0; e_wd = 0;
            if (!rst_n) begin
                m_active = 0; m_last = 1; m_rd[0] = 0; m_rd[1] = 0;
            end else begin
                if (m_active && cyc == m_g + 1 && !m_err) begin
                    e_mw = m_we; e_mr = !m_we; e_a = m_addr; e_wd = m_wd;
                    if (m_we) ref_mem[m_addr[6:0]] = m_wd;
                    else      m_val = ref_mem[m_addr[6:0]];
                end
                if (m_active && cyc == m_g + 2) begin
                    e_done[m_port] = 1'b1;
                    e_rv[m_port]   = !m_we;
                    e_err[m_port]  = m_err;
                    if (!m_we) m_rd[m_port] = m_val;
                    m_active = 0;
                end
                if (!m_active && (req[0] || req[1])) begin
`ifdef DM_ARB_RR_EN
                    w = (req[0] && req[1]) ? (m_last ? 0 : 1) : (req[1] ? 1 : 0);
`else
                    w = req[0] ? 0 : 1;
`endif
                    e_gnt[w] = 1'b1;
                    m_active = 1; m_g = cyc; m_port = w[0]; m_last = w[0];
                    m_we = we[w]; m_addr = addr[w]; m_wd = wdata[w];
                    m_err = (addr[w] >= 32'd128); m_val = 0;
                end
            end
            chk("gnt", {30'b0, gnt}, {30'b0, e_gnt});
            chk("done", {30'b0, done}, {30'b0, e_done});
            chk("rvalid", {30'b0, rvalid}, {30'b0, e_rv});
            chk("err", {30'b0, err}, {30'b0, e_err});
            chk("MemWrite", {31'b0, MemWrite}, {31'b0, e_mw});
            chk("MemRead", {31'b0, MemRead}, {31'b0, e_mr});
            chk("Address", Address, e_a);
            chk("WriteData", WriteData, e_wd);
            chk("p0_rdata", rdata[0], m_rd[0]);
            chk("p1_rdata", rdata[1], m_rd[1]);
            if (gnt[0]) begin log_port.push_back(0); log_cyc.push_back(cyc); end
            if (gnt[1]) begin log_port.push_back(1); log_cyc.push_back(cyc); end
            if (rvalid[0]) rd0_seq.push_back(rdata[0]);
        end
    end

    // Holds req for n grants, stepping addr/wdata after each grant, then drops it.
    task automatic burst(input int p, input logic w, input logic [31:0] a0,
                         input logic [31:0] d0, input int n);
        int t;
        for (int i = 0; i < n; i++) begin
            req[p] = 1'b1; we[p] = w; addr[p] = a0 + i; wdata[p] = d0 + i;
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!gnt[p] && t < 50);
            if (!gnt[p]) begin
                chk($sformatf("gnt_timeout_p%0d", p), 32'd0, 32'd1);
                req[p] = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        req[p] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin : stim
        for (int p = 0; p < 2; p++) begin
            req[p] = 0; we[p] = 0; addr[p] = 0; wdata[p] = 0;
        end
        idle(3);
        rst_n = 1'b1;
        idle(1);

        // write then read back on port 0
        burst(0, 1'b1, 32'd5, 32'h0000_CAFE, 1);
        burst(0, 1'b0, 32'd5, 32'd0, 1);
        idle(3);
        chk("t1_rdata", rdata[0], 32'h0000_CAFE);

        // simultaneous requests, both held for two grants
        log_port.delete(); log_cyc.delete();
        fork
            burst(0, 1'b0, 32'd10, 32'd0, 2);
            burst(1, 1'b0, 32'd20, 32'd0, 2);
        join
        idle(3);
        chk("t2_ngnt", log_port.size(), 4);
        if (log_port.size() == 4) begin
`ifdef DM_ARB_RR_EN
            chk("t2_order", {log_port[0][7:0], log_port[1][7:0], log_port[2][7:0], log_port[3][7:0]},
                32'h00_01_00_01);
`else
            chk("t2_order", {log_port[0][7:0], log_port[1][7:0], log_port[2][7:0], log_port[3][7:0]},
                32'h00_00_01_01);
`endif
            chk("t2_spacing", log_cyc[3] - log_cyc[0], 6);
        end
        chk("t2_p0_rdata", rdata[0], 32'h100B);
        chk("t2_p1_rdata", rdata[1], 32'h1015);

        // address boundary: 128 and a large value are blocked, 127 is a normal access
        burst(1, 1'b0, 32'd127, 32'd0, 1);
        idle(3);
        chk("t3_127", rdata[1], 32'h107F);
        burst(1, 1'b0, 32'd128, 32'd0, 1);
        idle(3);
        chk("t3_128", rdata[1], 32'h0);
        burst(1, 1'b1, 32'h8000_0005, 32'hBAD0, 1);
        burst(0, 1'b0, 32'd5, 32'd0, 1);
        idle(3);
        chk("t3_nowrap", rdata[0], 32'h0000_CAFE);

        // back-to-back reads with req held
        rd0_seq.delete(); log_cyc.delete();
        burst(0, 1'b0, 32'd0, 32'd0, 4);
        idle(3);
        chk("t4_nrd", rd0_seq.size(), 4);
        for (int i = 0; i < 4 && i < rd0_seq.size(); i++)
            chk($sformatf("t4_rd%0d", i), rd0_seq[i], 32'h1000 + i);
        if (log_cyc.size() == 4) chk("t4_spacing", log_cyc[3] - log_cyc[0], 6);

        // reset while port 1 write is in ACCESS
        burst(1, 1'b1, 32'd40, 32'hDEAD, 1);
        #1 rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(3);
        log_port.delete();
        fork
            burst(0, 1'b0, 32'd40, 32'd0, 1);
            burst(1, 1'b0, 32'd41, 32'd0, 1);
        join
        idle(3);
        if (log_port.size() > 0) chk("t5_first", log_port[0], 0);
        else chk("t5_first", 32'hFFFF_FFFF, 0);
        chk("t5_mem40", rdata[0], 32'h1028);
        chk("t5_mem41", rdata[1], 32'h1029);

        // p0 raised while p1 is in ACCESS
        log_port.delete(); log_cyc.delete();
        burst(1, 1'b1, 32'd50, 32'h5555, 1);
        burst(0, 1'b0, 32'd50, 32'd0, 1);
        idle(3);
        if (log_cyc.size() == 2) chk("t6_delay", log_cyc[1] - log_cyc[0], 2);
        else chk("t6_ngnt", log_cyc.size(), 2);
        chk("t6_rdata", rdata[0], 32'h5555);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
